// File: rtl/wbu_sender.sv
// Write-back producer: 2-entry skid buffer feeding the WBU, with outstanding tracking (optional perf counters: WBU_SENDER_PERF_EN).
// Latency: a payload accepted in cycle N is presented no earlier than cycle N+1.
// Backpressure: o_ready comes from registered state only; o_valid is held low once MAX_OUT write-backs await i_done.
module wbu_sender #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MAX_OUT = 1,
  parameter int CNT_W   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_reg_wena,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [REG_AW-1:0] o_rd,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_reg_wena,
  input  logic              i_done,
  output logic [CNT_W-1:0]  o_outstanding,
  output logic              o_idle,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_full_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] wdata;
    logic              wena;
  } wb_t;

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  state_e           state_q, state_d;
  wb_t              head_q, head_d, skid_q, skid_d, in_pl;
  logic [CNT_W-1:0] out_q, out_d;
  logic             push, pop, done_eff;

  assign in_pl    = '{rd: i_rd, wdata: i_wdata, wena: i_reg_wena};
  assign o_ready  = (state_q != TWO);
  assign o_valid  = (state_q != EMPTY) && (out_q < MAX_OUT_C);
  assign push     = i_valid && o_ready;
  assign pop      = o_valid && i_ready;
  // A done with nothing outstanding is spurious and must not wrap the counter.
  assign done_eff = i_done && (out_q != '0);

  assign o_rd          = head_q.rd;
  assign o_wdata       = head_q.wdata;
  assign o_reg_wena    = head_q.wena;
  assign o_outstanding = out_q;
  assign o_idle        = (state_q == EMPTY) && (out_q == '0);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_pl;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_pl;
        end else if (push) begin
          skid_d  = in_pl;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards buffered entries and any same-cycle push; a pop in this cycle is still counted below.
    if (i_flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end
  end

  always_comb begin
    out_d = out_q;
    if (pop && !done_eff) begin
      out_d = out_q + CNT_W'(1);
    end else if (!pop && done_eff) begin
      out_d = out_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      out_q   <= out_d;
    end
  end

`ifdef WBU_SENDER_PERF_EN
  logic [31:0] stall_q, stall_d, full_q, full_d;

  always_comb begin
    stall_d = stall_q + {31'd0, (o_valid && !i_ready)};
    full_d  = full_q + {31'd0, (i_valid && !o_ready)};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
      full_q  <= '0;
    end else begin
      stall_q <= stall_d;
      full_q  <= full_d;
    end
  end

  assign o_stall_cnt = stall_q;
  assign o_full_cnt  = full_q;
`else
  assign o_stall_cnt = '0;
  assign o_full_cnt  = '0;
`endif

endmodule

// File: tb/tb_wbu_sender.sv
// Directed bench for wbu_sender: main instance uses MAX_OUT=1, second instance MAX_OUT=2 for full-rate streaming.
module tb_wbu_sender;

  logic        clk, rst_n;
  logic        i_valid, i_reg_wena, i_flush, i_ready, i_done;
  logic [4:0]  i_rd;
  logic [31:0] i_wdata;
  logic        o_ready, o_valid, o_reg_wena, o_idle;
  logic [4:0]  o_rd;
  logic [31:0] o_wdata, o_stall_cnt, o_full_cnt;
  logic [1:0]  o_outstanding;

  logic        b_i_valid, b_i_reg_wena, b_i_flush, b_i_ready, b_i_done;
  logic [4:0]  b_i_rd;
  logic [31:0] b_i_wdata;
  logic        b_o_ready, b_o_valid, b_o_reg_wena, b_o_idle;
  logic [4:0]  b_o_rd;
  logic [31:0] b_o_wdata, b_o_stall_cnt, b_o_full_cnt;
  logic [1:0]  b_o_outstanding;

  int vectors = 0;
  int miscompares = 0;

`ifdef WBU_SENDER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  wbu_sender #(.DATA_W(32), .REG_AW(5), .MAX_OUT(1), .CNT_W(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rd(i_rd), .i_wdata(i_wdata), .i_reg_wena(i_reg_wena), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_rd(o_rd), .o_wdata(o_wdata),
    .o_reg_wena(o_reg_wena), .i_done(i_done), .o_outstanding(o_outstanding),
    .o_idle(o_idle), .o_stall_cnt(o_stall_cnt), .o_full_cnt(o_full_cnt)
  );

  wbu_sender #(.DATA_W(32), .REG_AW(5), .MAX_OUT(2), .CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_i_valid), .o_ready(b_o_ready),
    .i_rd(b_i_rd), .i_wdata(b_i_wdata), .i_reg_wena(b_i_reg_wena), .i_flush(b_i_flush),
    .o_valid(b_o_valid), .i_ready(b_i_ready), .o_rd(b_o_rd), .o_wdata(b_o_wdata),
    .o_reg_wena(b_o_reg_wena), .i_done(b_i_done), .o_outstanding(b_o_outstanding),
    .o_idle(b_o_idle), .o_stall_cnt(b_o_stall_cnt), .o_full_cnt(b_o_full_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic we);
    i_valid = v; i_rd = rd; i_wdata = d; i_reg_wena = we;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    i_flush = 0; i_ready = 0; i_done = 0;
    b_i_valid = 0; b_i_rd = 0; b_i_wdata = 0; b_i_reg_wena = 0;
    b_i_flush = 0; b_i_ready = 0; b_i_done = 0;
    #3;
    vectors++;
    if ({o_valid, o_ready, o_idle} !== 3'b011) begin
      miscompares++; $display("FAIL reset_flags: got %b want 011", {o_valid, o_ready, o_idle});
    end
    vectors++;
    if ({o_rd, o_wdata, o_reg_wena, o_outstanding} !== 40'd0) begin
      miscompares++; $display("FAIL reset_payload: got %h want 0", {o_rd, o_wdata, o_reg_wena, o_outstanding});
    end
    vectors++;
    if ({o_stall_cnt, o_full_cnt} !== 64'd0) begin
      miscompares++; $display("FAIL reset_perf: got %h want 0", {o_stall_cnt, o_full_cnt});
    end
    tick();
    rst_n = 1'b1;
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    vectors++;
    if ({o_outstanding, o_idle} !== 3'b001) begin
      miscompares++; $display("FAIL done_underflow: got %b want 001", {o_outstanding, o_idle});
    end
  endtask

  task automatic test_single();
    i_ready = 1'b1;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    vectors++;
    if ({o_valid, o_rd, o_wdata, o_reg_wena, o_outstanding} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 2'd0}) begin
      miscompares++; $display("FAIL single_present: got v=%b rd=%0d d=%h we=%b out=%0d want v=1 rd=5 d=deadbeef we=1 out=0",
                              o_valid, o_rd, o_wdata, o_reg_wena, o_outstanding);
    end
    tick();
    vectors++;
    if ({o_valid, o_outstanding, o_idle} !== 4'b0010) begin
      miscompares++; $display("FAIL single_sent: got %b want 0010", {o_valid, o_outstanding, o_idle});
    end
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    vectors++;
    if ({o_outstanding, o_idle} !== 3'b001) begin
      miscompares++; $display("FAIL single_done: got %b want 001", {o_outstanding, o_idle});
    end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    drive(1'b1, 5'd1, 32'h11, 1'b1);
    tick();
    drive(1'b1, 5'd2, 32'h22, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    vectors++;
    if ({o_valid, o_ready, o_rd, o_wdata, o_reg_wena} !== {1'b1, 1'b0, 5'd1, 32'h11, 1'b1}) begin
      miscompares++; $display("FAIL bp_hold_a: got v=%b r=%b rd=%0d d=%h want v=1 r=0 rd=1 d=11",
                              o_valid, o_ready, o_rd, o_wdata);
    end
    i_ready = 1'b1;
    tick();
    vectors++;
    if ({o_valid, o_ready, o_rd, o_wdata, o_outstanding} !== {1'b0, 1'b1, 5'd2, 32'h22, 2'd1}) begin
      miscompares++; $display("FAIL bp_after_a: got v=%b r=%b rd=%0d d=%h out=%0d want v=0 r=1 rd=2 d=22 out=1",
                              o_valid, o_ready, o_rd, o_wdata, o_outstanding);
    end
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    vectors++;
    if ({o_valid, o_rd, o_wdata, o_reg_wena, o_outstanding} !== {1'b1, 5'd2, 32'h22, 1'b0, 2'd0}) begin
      miscompares++; $display("FAIL bp_present_b: got v=%b rd=%0d d=%h we=%b out=%0d want v=1 rd=2 d=22 we=0 out=0",
                              o_valid, o_rd, o_wdata, o_reg_wena, o_outstanding);
    end
    tick();
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    vectors++;
    if ({o_valid, o_idle, o_outstanding} !== 4'b0100) begin
      miscompares++; $display("FAIL bp_drained: got %b want 0100", {o_valid, o_idle, o_outstanding});
    end
  endtask

  task automatic test_out_limit();
    i_ready = 1'b1;
    drive(1'b1, 5'd7, 32'hA0, 1'b1);
    tick();
    drive(1'b1, 5'd8, 32'hB0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({o_valid, o_outstanding, o_wdata} !== {1'b0, 2'd1, 32'hB0}) begin
        miscompares++; $display("FAIL limit_hold%0d: got v=%b out=%0d d=%h want v=0 out=1 d=b0",
                                k, o_valid, o_outstanding, o_wdata);
      end
      tick();
    end
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    vectors++;
    if ({o_valid, o_rd, o_wdata} !== {1'b1, 5'd8, 32'hB0}) begin
      miscompares++; $display("FAIL limit_release: got v=%b rd=%0d d=%h want v=1 rd=8 d=b0", o_valid, o_rd, o_wdata);
    end
    tick();
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    vectors++;
    if (o_idle !== 1'b1) begin
      miscompares++; $display("FAIL limit_idle: got %b want 1", o_idle);
    end
  endtask

  task automatic test_back_to_back();
    b_i_ready = 1'b1;
    b_i_done = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      b_i_valid = 1'b1; b_i_rd = 5'(k); b_i_wdata = 32'(k); b_i_reg_wena = 1'b1;
      tick();
      vectors++;
      if ({b_o_valid, b_o_ready, b_o_rd, b_o_wdata, b_o_outstanding} !==
          {1'b1, 1'b1, 5'(k), 32'(k), (k == 1) ? 2'd0 : 2'd1}) begin
        miscompares++; $display("FAIL b2b_%0d: got v=%b r=%b rd=%0d d=%0d out=%0d want v=1 r=1 rd=%0d d=%0d out=%0d",
                                k, b_o_valid, b_o_ready, b_o_rd, b_o_wdata, b_o_outstanding, k, k, (k == 1) ? 0 : 1);
      end
    end
    b_i_valid = 1'b0;
    tick();
    vectors++;
    if ({b_o_valid, b_o_outstanding} !== 3'b001) begin
      miscompares++; $display("FAIL b2b_last_sent: got %b want 001", {b_o_valid, b_o_outstanding});
    end
    tick();
    b_i_done = 1'b0;
    vectors++;
    if (b_o_idle !== 1'b1) begin
      miscompares++; $display("FAIL b2b_idle: got %b want 1", b_o_idle);
    end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    drive(1'b1, 5'd1, 32'hA1, 1'b1);
    tick();
    drive(1'b1, 5'd2, 32'hB2, 1'b1);
    tick();
    drive(1'b1, 5'd3, 32'hC3, 1'b1);
    i_flush = 1'b1;
    i_ready = 1'b1;
    tick();
    i_flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    vectors++;
    if ({o_valid, o_ready, o_idle, o_outstanding} !== 5'b01001) begin
      miscompares++; $display("FAIL flush_state: got %b want 01001", {o_valid, o_ready, o_idle, o_outstanding});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (o_valid !== 1'b0) begin
        miscompares++; $display("FAIL flush_quiet%0d: got %b want 0", k, o_valid);
      end
    end
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    vectors++;
    if ({o_valid, o_idle, o_outstanding} !== 4'b0100) begin
      miscompares++; $display("FAIL flush_drain: got %b want 0100", {o_valid, o_idle, o_outstanding});
    end
  endtask

  task automatic test_perf();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    i_ready = 1'b0;
    drive(1'b1, 5'd9, 32'h99, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    repeat (10) tick();
    vectors++;
    if (o_stall_cnt !== (PERF ? 32'd10 : 32'd0)) begin
      miscompares++; $display("FAIL perf_stall: got %0d want %0d", o_stall_cnt, PERF ? 10 : 0);
    end
    drive(1'b1, 5'd10, 32'hAA, 1'b1);
    tick();
    repeat (3) tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    vectors++;
    if ({o_full_cnt, o_stall_cnt} !== (PERF ? {32'd3, 32'd14} : 64'd0)) begin
      miscompares++; $display("FAIL perf_full: got full=%0d stall=%0d want full=%0d stall=%0d",
                              o_full_cnt, o_stall_cnt, PERF ? 3 : 0, PERF ? 14 : 0);
    end
  endtask

  task automatic test_midreset();
    vectors++;
    if ({o_valid, o_ready} !== 2'b10) begin
      miscompares++; $display("FAIL midrst_pre: got %b want 10", {o_valid, o_ready});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_valid, o_ready, o_idle, o_outstanding, o_wdata, o_stall_cnt, o_full_cnt} !== {3'b011, 98'd0}) begin
      miscompares++; $display("FAIL midrst_clear: got v=%b r=%b idle=%b out=%0d d=%h stall=%0d full=%0d want 0 1 1 0 0 0 0",
                              o_valid, o_ready, o_idle, o_outstanding, o_wdata, o_stall_cnt, o_full_cnt);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_out_limit();
    test_back_to_back();
    test_flush();
    test_perf();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
